writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_if.sv | 45 ++++
 rtl/writeback_stage.sv | 200 ++++++++++++++++++++
 tb/tb_writeback_stage.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Bundle between the decode stage, the bus interface and the writeback stage.
// Handshake: an instruction moves on a rising edge where in_valid & in_ready are both high.
interface writeback_stage_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_INDEX_WIDTH = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [31:0]                inbound_instruction;
  logic [DATA_WIDTH-1:0]      return_address;
  logic [DATA_WIDTH-1:0]      mem_data;
  logic                       mem_data_valid;
  logic                       alu_carry;
  logic                       alu_zero;
  logic                       alu_neg;
  logic                       alu_over;
  logic                       out_valid;
  logic [31:0]                outbound_instruction;
  logic [REG_INDEX_WIDTH-1:0] write_index;
  logic                       write;
  logic [DATA_WIDTH-1:0]      write_data;
  logic                       write_immediate;
  logic [15:0]                write_immediate_data;
  logic [1:0]                 write_immediate_type;
  logic                       alu_cycle;
  logic                       status_register_write;
  logic                       jump;
  logic                       load_fault;

  modport slave (
    input  in_valid, inbound_instruction, return_address, mem_data, mem_data_valid,
           alu_carry, alu_zero, alu_neg, alu_over,
    output in_ready, out_valid, outbound_instruction, write_index, write, write_data,
           write_immediate, write_immediate_data, write_immediate_type, alu_cycle,
           status_register_write, jump, load_fault
  );

  modport master (
    output in_valid, inbound_instruction, return_address, mem_data, mem_data_valid,
           alu_carry, alu_zero, alu_neg, alu_over,
    input  in_ready, out_valid, outbound_instruction, write_index, write, write_data,
           write_immediate, write_immediate_data, write_immediate_type, alu_cycle,
           status_register_write, jump, load_fault
  );
endinterface

// File: rtl/writeback_stage.sv
// Pipeline stage 2: commits ALU/immediate/link results, waits for load data
// with a timeout, and squashes the slots that follow a taken jump.
module writeback_stage #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_INDEX_WIDTH = 4,
  parameter int SQUASH_SLOTS    = 1,
  parameter int LOAD_TIMEOUT    = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  writeback_stage_if.slave     bus,
  output logic [1:0]           o_dbg_state
);
  localparam logic [4:0] OPCODE_NOP    = 5'd0;
  localparam logic [4:0] OPCODE_ALU    = 5'd1;
  localparam logic [4:0] OPCODE_ALUM   = 5'd2;
  localparam logic [4:0] OPCODE_ALUMI  = 5'd3;
  localparam logic [4:0] OPCODE_LOADI  = 5'd4;
  localparam logic [4:0] OPCODE_LOAD   = 5'd5;
  localparam logic [4:0] OPCODE_LOADR  = 5'd6;
  localparam logic [4:0] OPCODE_BRANCH = 5'd7;
  localparam logic [4:0] OPCODE_JUMP   = 5'd8;
  localparam logic [1:0] CW_BYTE       = 2'd0;
  localparam logic [1:0] CW_WORD       = 2'd1;
  localparam logic [1:0] IT_UNSIGNED   = 2'd0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT_MEM = 2'd1} state_t;

  state_t                     r_state;
  logic [2:0]                 r_squash;
  logic [7:0]                 r_timeout;
  logic [31:0]                r_load_instr;
  logic                       r_out_valid, r_write, r_write_imm, r_alu_cycle;
  logic                       r_status_write, r_jump, r_load_fault;
  logic [31:0]                r_outbound;
  logic [REG_INDEX_WIDTH-1:0] r_write_index;
  logic [DATA_WIDTH-1:0]      r_write_data;
  logic [15:0]                r_imm_data;
  logic [1:0]                 r_imm_type;

  logic                       w_cond_true;
  logic                       w_nv;
  logic [4:0]                 w_opcode;
  logic [REG_INDEX_WIDTH-1:0] w_index;
  logic [REG_INDEX_WIDTH-1:0] w_load_index;
  logic [DATA_WIDTH-1:0]      w_load_value;

  assign w_opcode     = bus.inbound_instruction[31:27];
  assign w_index      = bus.inbound_instruction[20 +: REG_INDEX_WIDTH];
  assign w_load_index = r_load_instr[20 +: REG_INDEX_WIDTH];
  assign w_nv         = bus.alu_neg ^ bus.alu_over;

  always_comb begin
    w_cond_true = 1'b0;
    case (bus.inbound_instruction[15:12])
      4'd0:    w_cond_true = 1'b1;
      4'd1:    w_cond_true = bus.alu_zero;
      4'd2:    w_cond_true = ~bus.alu_zero;
      4'd3:    w_cond_true = bus.alu_carry;
      4'd4:    w_cond_true = ~bus.alu_carry;
      4'd5:    w_cond_true = bus.alu_neg;
      4'd6:    w_cond_true = ~bus.alu_neg;
      4'd7:    w_cond_true = bus.alu_over;
      4'd8:    w_cond_true = ~bus.alu_over;
      4'd9:    w_cond_true = ~bus.alu_carry & ~bus.alu_zero;
      4'd10:   w_cond_true = bus.alu_carry | bus.alu_zero;
      4'd11:   w_cond_true = ~w_nv;
      4'd12:   w_cond_true = w_nv;
      4'd13:   w_cond_true = ~bus.alu_zero & ~w_nv;
      4'd14:   w_cond_true = bus.alu_zero | w_nv;
      default: w_cond_true = 1'b0;
    endcase
  end

  // Bit 24 of the latched load selects sign extension of the chosen width.
  always_comb begin
    w_load_value = '0;
    case (r_load_instr[26:25])
      CW_BYTE: w_load_value = r_load_instr[24] ? DATA_WIDTH'($signed(bus.mem_data[7:0]))
                                               : DATA_WIDTH'(bus.mem_data[7:0]);
      CW_WORD: w_load_value = r_load_instr[24] ? DATA_WIDTH'($signed(bus.mem_data[15:0]))
                                               : DATA_WIDTH'(bus.mem_data[15:0]);
      default: w_load_value = r_load_instr[24] ? DATA_WIDTH'($signed(bus.mem_data[31:0]))
                                               : DATA_WIDTH'(bus.mem_data[31:0]);
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_squash       <= '0;
      r_timeout      <= '0;
      r_load_instr   <= '0;
      r_out_valid    <= 1'b0;
      r_write        <= 1'b0;
      r_write_imm    <= 1'b0;
      r_alu_cycle    <= 1'b0;
      r_status_write <= 1'b0;
      r_jump         <= 1'b0;
      r_load_fault   <= 1'b0;
      r_outbound     <= {OPCODE_NOP, 27'h0};
      r_write_index  <= '0;
      r_write_data   <= '0;
      r_imm_data     <= '0;
      r_imm_type     <= IT_UNSIGNED;
    end else begin
      r_out_valid    <= 1'b0;
      r_write        <= 1'b0;
      r_write_imm    <= 1'b0;
      r_alu_cycle    <= 1'b0;
      r_status_write <= 1'b0;
      r_jump         <= 1'b0;
      r_load_fault   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (r_squash != 3'd0) begin
              r_squash   <= r_squash - 3'd1;
              r_outbound <= {OPCODE_NOP, 27'h0};
            end else begin
              case (w_opcode)
                OPCODE_LOADI: begin
                  r_outbound    <= bus.inbound_instruction;
                  r_out_valid   <= 1'b1;
                  r_write_imm   <= 1'b1;
                  r_write_index <= w_index;
                  r_imm_type    <= bus.inbound_instruction[26:25];
                  r_imm_data    <= bus.inbound_instruction[15:0];
                end
                OPCODE_ALU, OPCODE_ALUM, OPCODE_ALUMI: begin
                  r_outbound     <= bus.inbound_instruction;
                  r_out_valid    <= 1'b1;
                  r_alu_cycle    <= 1'b1;
                  r_status_write <= 1'b1;
                  r_write        <= 1'b1;
                  r_write_index  <= w_index;
                end
                OPCODE_BRANCH, OPCODE_JUMP: begin
                  r_outbound  <= bus.inbound_instruction;
                  r_out_valid <= 1'b1;
                  if (w_cond_true) begin
                    r_jump   <= 1'b1;
                    r_squash <= 3'(SQUASH_SLOTS);
                    if (bus.inbound_instruction[24]) begin
                      r_write       <= 1'b1;
                      r_write_data  <= bus.return_address;
                      r_write_index <= w_index;
                    end
                  end
                end
                OPCODE_LOAD, OPCODE_LOADR: begin
                  r_load_instr <= bus.inbound_instruction;
                  r_timeout    <= '0;
                  r_state      <= S_WAIT_MEM;
                end
                default: begin
                  r_outbound  <= bus.inbound_instruction;
                  r_out_valid <= 1'b1;
                end
              endcase
            end
          end
        end
        S_WAIT_MEM: begin
          if (bus.mem_data_valid) begin
            r_write       <= 1'b1;
            r_write_index <= w_load_index;
            r_write_data  <= w_load_value;
            r_out_valid   <= 1'b1;
            r_outbound    <= r_load_instr;
            r_state       <= S_IDLE;
          end else if (r_timeout == 8'(LOAD_TIMEOUT - 1)) begin
            r_load_fault <= 1'b1;
            r_out_valid  <= 1'b1;
            r_outbound   <= r_load_instr;
            r_state      <= S_IDLE;
          end else begin
            r_timeout <= r_timeout + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready              = (r_state == S_IDLE);
  assign bus.out_valid             = r_out_valid;
  assign bus.outbound_instruction  = r_outbound;
  assign bus.write_index           = r_write_index;
  assign bus.write                 = r_write;
  assign bus.write_data            = r_write_data;
  assign bus.write_immediate       = r_write_imm;
  assign bus.write_immediate_data  = r_imm_data;
  assign bus.write_immediate_type  = r_imm_type;
  assign bus.alu_cycle             = r_alu_cycle;
  assign bus.status_register_write = r_status_write;
  assign bus.jump                  = r_jump;
  assign bus.load_fault            = r_load_fault;
  assign o_dbg_state               = r_state;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus random instruction mix,
// every output compared against a transaction-level model of the stage.
module tb_writeback_stage;
  localparam int DW  = 32;
  localparam int RIW = 4;
  localparam int SQ  = 1;
  localparam int LT  = 15;

  localparam logic [4:0] OP_NOP    = 5'd0;
  localparam logic [4:0] OP_ALU    = 5'd1;
  localparam logic [4:0] OP_ALUM   = 5'd2;
  localparam logic [4:0] OP_ALUMI  = 5'd3;
  localparam logic [4:0] OP_LOADI  = 5'd4;
  localparam logic [4:0] OP_LOAD   = 5'd5;
  localparam logic [4:0] OP_LOADR  = 5'd6;
  localparam logic [4:0] OP_BRANCH = 5'd7;
  localparam logic [4:0] OP_JUMP   = 5'd8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  writeback_stage_if #(.DATA_WIDTH(DW), .REG_INDEX_WIDTH(RIW)) bus();

  writeback_stage #(
    .DATA_WIDTH(DW), .REG_INDEX_WIDTH(RIW), .SQUASH_SLOTS(SQ), .LOAD_TIMEOUT(LT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Expected view of the stage outputs; held values persist across transactions.
  logic [31:0]     exp_outbound;
  logic [RIW-1:0]  exp_index;
  logic [DW-1:0]   exp_wdata;
  logic [15:0]     exp_imm;
  logic [1:0]      exp_itype;
  logic            exp_ov, exp_wr, exp_wimm, exp_alu, exp_sr, exp_jump, exp_fault;
  int              exp_squash;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [1:0] typ,
                                     input logic f, input logic [3:0] idx, input logic [15:0] low);
    return {op, typ, f, idx, 4'h0, low};
  endfunction

  function automatic bit cond_holds(input logic [3:0] cc, input logic [3:0] flg);
    bit c, z, n, v;
    {c, z, n, v} = flg;
    case (cc)
      4'd0:  return 1;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return c;
      4'd4:  return !c;
      4'd5:  return n;
      4'd6:  return !n;
      4'd7:  return v;
      4'd8:  return !v;
      4'd9:  return !c && !z;
      4'd10: return c || z;
      4'd11: return n == v;
      4'd12: return n != v;
      4'd13: return !z && (n == v);
      4'd14: return z || (n != v);
      default: return 0;
    endcase
  endfunction

  function automatic logic [DW-1:0] load_value(input logic [31:0] ins, input logic [63:0] d);
    longint unsigned span, v;
    case (ins[26:25])
      2'd0:    span = 64'd256;
      2'd1:    span = 64'd65536;
      default: span = 64'h1_0000_0000;
    endcase
    v = d % span;
    if (ins[24] && v >= span / 2) v = v - span;
    return DW'(v);
  endfunction

  task automatic model_reset();
    exp_outbound = {OP_NOP, 27'h0};
    exp_index = '0; exp_wdata = '0; exp_imm = '0; exp_itype = 2'd0;
    exp_ov = 0; exp_wr = 0; exp_wimm = 0; exp_alu = 0; exp_sr = 0; exp_jump = 0; exp_fault = 0;
    exp_squash = 0;
  endtask

  task automatic clear_pulses();
    exp_ov = 0; exp_wr = 0; exp_wimm = 0; exp_alu = 0; exp_sr = 0; exp_jump = 0; exp_fault = 0;
  endtask

  task automatic model_accept(input logic [31:0] ins, input logic [3:0] flg, input logic [DW-1:0] ra);
    logic [4:0] op;
    clear_pulses();
    if (exp_squash > 0) begin
      exp_squash--;
      exp_outbound = {OP_NOP, 27'h0};
      return;
    end
    op = ins[31:27];
    exp_outbound = ins;
    exp_ov = 1;
    if (op == OP_LOADI) begin
      exp_wimm = 1; exp_index = ins[23:20]; exp_itype = ins[26:25]; exp_imm = ins[15:0];
    end else if (op == OP_ALU || op == OP_ALUM || op == OP_ALUMI) begin
      exp_alu = 1; exp_sr = 1; exp_wr = 1; exp_index = ins[23:20];
    end else if ((op == OP_BRANCH || op == OP_JUMP) && cond_holds(ins[15:12], flg)) begin
      exp_jump = 1;
      exp_squash = SQ;
      if (ins[24]) begin
        exp_wr = 1; exp_wdata = ra; exp_index = ins[23:20];
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".outbound"}, bus.outbound_instruction, exp_outbound);
    check({tag, ".windex"},   bus.write_index, exp_index);
    check({tag, ".wdata"},    bus.write_data, exp_wdata);
    check({tag, ".immdata"},  bus.write_immediate_data, exp_imm);
    check({tag, ".immtype"},  bus.write_immediate_type, exp_itype);
    check({tag, ".ovalid"},   bus.out_valid, exp_ov);
    check({tag, ".write"},    bus.write, exp_wr);
    check({tag, ".wimm"},     bus.write_immediate, exp_wimm);
    check({tag, ".alucyc"},   bus.alu_cycle, exp_alu);
    check({tag, ".srwrite"},  bus.status_register_write, exp_sr);
    check({tag, ".jump"},     bus.jump, exp_jump);
    check({tag, ".fault"},    bus.load_fault, exp_fault);
  endtask

  task automatic scramble_idle_inputs();
    bus.inbound_instruction = $urandom;
    {bus.alu_carry, bus.alu_zero, bus.alu_neg, bus.alu_over} = 4'($urandom_range(0, 15));
    bus.return_address = DW'($urandom);
    bus.mem_data = DW'($urandom);
  endtask

  task automatic issue(input string tag, input logic [31:0] ins, input logic [3:0] flg,
                       input logic [DW-1:0] ra);
    @(negedge clock);
    check({tag, ".ready"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.inbound_instruction = ins;
    {bus.alu_carry, bus.alu_zero, bus.alu_neg, bus.alu_over} = flg;
    bus.return_address = ra;
    bus.mem_data_valid = 1'b0;
    model_accept(ins, flg, ra);
    @(negedge clock);
    bus.in_valid = 1'b0;
    scramble_idle_inputs();
    check_all(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
    clear_pulses();
    check_all("idle");
  endtask

  // k is the WAIT_MEM cycle (1-based) in which data arrives; give=0 lets it time out.
  task automatic do_load(input string tag, input logic [31:0] ins, input int k, input bit give,
                         input logic [DW-1:0] data);
    if (exp_squash > 0) begin
      issue(tag, ins, 4'($urandom_range(0, 15)), DW'($urandom));
      return;
    end
    @(negedge clock);
    check({tag, ".ready"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.inbound_instruction = ins;
    bus.mem_data_valid = 1'b1;
    bus.mem_data = DW'($urandom);
    for (int w = 1; w <= LT; w++) begin
      @(negedge clock);
      check({tag, ".busy"}, bus.in_ready, 1'b0);
      if (w == 1) check({tag, ".nopulse"}, bus.out_valid, 1'b0);
      bus.in_valid = 1'($urandom_range(0, 1));
      scramble_idle_inputs();
      bus.mem_data_valid = 1'b0;
      if (give && w == k) begin
        bus.mem_data_valid = 1'b1;
        bus.mem_data = data;
        break;
      end
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.mem_data_valid = 1'b0;
    clear_pulses();
    exp_ov = 1;
    exp_outbound = ins;
    if (give) begin
      exp_wr = 1; exp_index = ins[23:20]; exp_wdata = load_value(ins, 64'(data));
    end else begin
      exp_fault = 1;
    end
    check_all(tag);
    check({tag, ".readyback"}, bus.in_ready, 1'b1);
  endtask

  task automatic reset_in_wait();
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.inbound_instruction = mk(OP_LOADR, 2'd2, 1'b0, 4'd9, 16'h0);
    bus.mem_data_valid = 1'b0;
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(negedge clock);
    check("rstwait.busy", bus.in_ready, 1'b0);
    reset = 1'b1;
    bus.mem_data_valid = 1'b1;
    bus.mem_data = DW'(32'hDEAD_BEEF);
    @(negedge clock);
    reset = 1'b0;
    bus.mem_data_valid = 1'b0;
    model_reset();
    check_all("rstwait");
    @(negedge clock);
    check("rstwait.ready", bus.in_ready, 1'b1);
    check_all("rstwait.after");
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] ins;
    bus.in_valid = 1'b0;
    bus.mem_data_valid = 1'b0;
    scramble_idle_inputs();
    model_reset();
    repeat (3) @(negedge clock);
    check_all("reset");
    reset = 1'b0;
    @(negedge clock);
    check("reset.ready", bus.in_ready, 1'b1);

    issue("loadi", mk(OP_LOADI, 2'd0, 1'b0, 4'd3, 16'h1234), 4'h0, '0);
    check("loadi.const", bus.write_immediate_data, 16'h1234);
    check("loadi.idx", bus.write_index, 4'd3);

    do_load("ldbyte", mk(OP_LOAD, 2'd0, 1'b1, 4'd5, 16'h0), 3, 1'b1, DW'(32'h0000_0080));
    check("ldbyte.const", bus.write_data, DW'(32'hFFFF_FF80));

    do_load("ldtimeout", mk(OP_LOAD, 2'd2, 1'b0, 4'd6, 16'h0), 0, 1'b0, '0);

    issue("beq", mk(OP_BRANCH, 2'd0, 1'b1, 4'd14, 16'h1000), 4'b0100, DW'(32'h100));
    check("beq.const", bus.write_data, DW'(32'h100));
    issue("squashed", mk(OP_ALU, 2'd0, 1'b0, 4'd2, 16'h0), 4'h0, '0);
    check("squashed.nop", bus.outbound_instruction, {OP_NOP, 27'h0});
    issue("alu", mk(OP_ALU, 2'd0, 1'b0, 4'd2, 16'h0), 4'h0, '0);

    issue("bgt.taken", mk(OP_BRANCH, 2'd0, 1'b0, 4'd1, 16'hD000), 4'b0011, '0);
    issue("absorb", mk(OP_NOP, 2'd0, 1'b0, 4'd0, 16'h0), 4'h0, '0);
    issue("bgt.nottaken", mk(OP_BRANCH, 2'd0, 1'b0, 4'd1, 16'hD000), 4'b0010, '0);

    reset_in_wait();

    for (int t = 0; t < 250; t++) begin
      int sel;
      sel = $urandom_range(0, 12);
      op = (sel > 8) ? 5'($urandom_range(9, 31)) : 5'(sel);
      ins = {op, 27'($urandom)};
      if (op == OP_LOAD || op == OP_LOADR)
        do_load("rnd.load", ins, $urandom_range(1, LT), $urandom_range(0, 4) != 0, DW'($urandom));
      else
        issue("rnd", ins, 4'($urandom_range(0, 15)), DW'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
